// File: rtl/parity_serial_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : parity_serial_rx_pkg
// Purpose  : Shared constants for the parity serial receiver. It holds the
//            default frame geometry, the FSM state encodings and the helper
//            that decides whether a received frame has a parity error.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package parity_serial_rx_pkg;

    // Default frame geometry
    localparam int c_CLKS_PER_BIT_DEF = 16;
    localparam int c_DATA_BITS_DEF    = 8;

    // FSM state encodings
    localparam int c_STATE_W = 3;
    typedef logic [c_STATE_W-1:0] state_t;

    localparam state_t c_ST_IDLE      = 3'd0;
    localparam state_t c_ST_START     = 3'd1;
    localparam state_t c_ST_DATA      = 3'd2;
    localparam state_t c_ST_PARITY    = 3'd3;
    localparam state_t c_ST_STOP      = 3'd4;
    localparam state_t c_ST_WAIT_IDLE = 3'd5;

    // An error exists when the total number of ones (data plus parity bit)
    // does not have the parity selected by odd_sel.
    function automatic logic parity_error(input logic even_flag,
                                          input logic odd_flag,
                                          input logic odd_sel);
        return odd_sel ? even_flag : odd_flag;
    endfunction

endpackage : parity_serial_rx_pkg
`default_nettype wire

// File: rtl/parity_serial_rx_parity9.sv
`default_nettype none
// ============================================================================
// Module   : parity9
// Purpose  : Combinational 9-bit parity generator used to check the data word
//            together with its received parity bit.
// Ports    : bits_in [8:0] - data bits (zero padded) plus the parity bit
//            even          - 1 when bits_in holds an even number of ones
//            odd           - 1 when bits_in holds an odd number of ones
// Revision : 1.0 - initial release
// ============================================================================
module parity9 (
    input  logic [8:0] bits_in,
    output logic       even,
    output logic       odd
);

    assign odd  = ^bits_in;
    assign even = ~odd;

endmodule : parity9
`default_nettype wire

// File: rtl/parity_serial_rx.sv
`default_nettype none
// ============================================================================
// Module   : parity_serial_rx
// Purpose  : UART-style serial receiver with a parity check. A frame is
//            start(0), DATA_BITS data bits LSB first, one parity bit and a
//            stop(1) bit. Each bit is sampled at its centre.
// Ports    : clk        - clock, rising edge
//            rst_n      - asynchronous active-low reset
//            rx_in      - serial line, idle high
//            odd_sel    - 1 = odd parity, 0 = even parity (used at parity bit)
//            data_out   - last received word, held until the next frame
//            data_valid - one-clock pulse when data_out / error flags update
//            parity_err - data plus parity bit violate the selected parity
//            frame_err  - stop bit sampled 0
//            busy       - 1 in every state except IDLE
// Options  : define PARITY_RX_SYNC_EN to pass rx_in through a two-flop
//            synchronizer (reset to 1), adding two clocks of latency.
// Revision : 1.0 - initial release
// ============================================================================
module parity_serial_rx
    import parity_serial_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = c_CLKS_PER_BIT_DEF,
    parameter int DATA_BITS    = c_DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_in,
    input  logic                 odd_sel,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    // Clock counter never needs to hold more than CLKS_PER_BIT-1.
    localparam int c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_BIT_W = 4;

    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_FULL_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_ONE   = c_BIT_W'(1);
    localparam logic [c_BIT_W-1:0] c_BITS_LAST = c_BIT_W'(DATA_BITS - 1);

    // ------------------------------------------------------------------
    // Line input conditioning
    // ------------------------------------------------------------------
    logic w_rx;

`ifdef PARITY_RX_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    // Reset to the idle level so a reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx = r_sync2;
`else
    assign w_rx = rx_in;
`endif

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_BIT_W-1:0]   r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_err_pend;
    logic [DATA_BITS-1:0] r_data_out;
    logic                 r_data_valid;
    logic                 r_parity_err;
    logic                 r_frame_err;

    // ------------------------------------------------------------------
    // Next-state signals
    // ------------------------------------------------------------------
    state_t               w_state_next;
    logic [c_CNT_W-1:0]   w_cnt_next;
    logic [c_BIT_W-1:0]   w_bit_next;
    logic                 w_shift_en;
    logic                 w_par_capture;
    logic                 w_frame_done;
    logic [DATA_BITS-1:0] w_shift_in;

    // New bits enter at the MSB so that after DATA_BITS shifts the first
    // (least significant) bit received sits at bit 0.
    generate
        if (DATA_BITS == 1) begin : g_shift_one
            assign w_shift_in = w_rx;
        end else begin : g_shift_multi
            assign w_shift_in = {w_rx, r_shift[DATA_BITS-1:1]};
        end
    endgenerate

    // ------------------------------------------------------------------
    // Parity check, evaluated at the parity-bit sample point. The shift
    // register already holds the full word at that moment.
    // ------------------------------------------------------------------
    logic [7:0] w_data8;
    logic       w_par_even;
    logic       w_par_odd;
    logic       w_par_err;

    assign w_data8 = 8'(r_shift);

    parity9 u_parity9 (
        .bits_in ({w_rx, w_data8}),
        .even    (w_par_even),
        .odd     (w_par_odd)
    );

    assign w_par_err = parity_error(w_par_even, w_par_odd, odd_sel);

    // ------------------------------------------------------------------
    // FSM: next state and control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt + c_CNT_ONE;
        w_bit_next    = r_bit;
        w_shift_en    = 1'b0;
        w_par_capture = 1'b0;
        w_frame_done  = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                w_cnt_next = '0;
                w_bit_next = '0;
                if (!w_rx) begin
                    w_state_next = c_ST_START;
                end
            end

            c_ST_START: begin
                // Mid-start-bit check rejects short glitches.
                if (r_cnt == c_HALF_LAST) begin
                    w_cnt_next   = '0;
                    w_state_next = w_rx ? c_ST_IDLE : c_ST_DATA;
                end
            end

            c_ST_DATA: begin
                if (r_cnt == c_FULL_LAST) begin
                    w_cnt_next = '0;
                    w_shift_en = 1'b1;
                    if (r_bit == c_BITS_LAST) begin
                        w_bit_next   = '0;
                        w_state_next = c_ST_PARITY;
                    end else begin
                        w_bit_next = r_bit + c_BIT_ONE;
                    end
                end
            end

            c_ST_PARITY: begin
                if (r_cnt == c_FULL_LAST) begin
                    w_cnt_next    = '0;
                    w_par_capture = 1'b1;
                    w_state_next  = c_ST_STOP;
                end
            end

            c_ST_STOP: begin
                if (r_cnt == c_FULL_LAST) begin
                    w_cnt_next   = '0;
                    w_frame_done = 1'b1;
                    w_state_next = w_rx ? c_ST_IDLE : c_ST_WAIT_IDLE;
                end
            end

            c_ST_WAIT_IDLE: begin
                // A low stop bit may be a break; wait for the line to go idle
                // before hunting for the next start bit.
                w_cnt_next = '0;
                if (w_rx) begin
                    w_state_next = c_ST_IDLE;
                end
            end

            default: begin
                w_cnt_next   = '0;
                w_bit_next   = '0;
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM state and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= c_ST_IDLE;
            r_cnt          <= '0;
            r_bit          <= '0;
            r_shift        <= '0;
            r_par_err_pend <= 1'b0;
            r_data_out     <= '0;
            r_data_valid   <= 1'b0;
            r_parity_err   <= 1'b0;
            r_frame_err    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_bit        <= w_bit_next;
            r_data_valid <= w_frame_done;

            if (w_shift_en) begin
                r_shift <= w_shift_in;
            end

            if (w_par_capture) begin
                r_par_err_pend <= w_par_err;
            end

            // Both error flags are reported together and the word is
            // delivered regardless of either error.
            if (w_frame_done) begin
                r_data_out   <= r_shift;
                r_parity_err <= r_par_err_pend;
                r_frame_err  <= ~w_rx;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign busy       = (r_state != c_ST_IDLE);

endmodule : parity_serial_rx
`default_nettype wire

// File: tb/tb_parity_serial_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_parity_serial_rx
// Purpose  : Self-checking bench for parity_serial_rx (CLKS_PER_BIT=16,
//            DATA_BITS=8). Directed frames are driven on rx_in; a frame-level
//            model predicts data, error flags and delivery time, and a
//            compare process checks every data_valid pulse against it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_parity_serial_rx;

    localparam int c_CPB = 16;
    localparam int c_DB  = 8;
`ifdef PARITY_RX_SYNC_EN
    localparam int c_SYNC_LAT = 2;
`else
    localparam int c_SYNC_LAT = 0;
`endif
    // Clocks from the start-bit falling edge to the data_valid rise.
    localparam int c_LAT = (c_DB + 2) * c_CPB + c_CPB / 2 + 1 + c_SYNC_LAT;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           rx_in;
    logic           odd_sel;
    logic [c_DB-1:0] data_out;
    logic           data_valid;
    logic           parity_err;
    logic           frame_err;
    logic           busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        int         start_cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_cur;

    parity_serial_rx #(
        .CLKS_PER_BIT (c_CPB),
        .DATA_BITS    (c_DB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_in      (rx_in),
        .odd_sel    (odd_sel),
        .data_out   (data_out),
        .data_valid (data_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, req);
        end
    endtask

    // Parity rule: error when the count of ones in data plus parity bit is
    // not odd (odd_sel=1) or not even (odd_sel=0).
    function automatic logic model_perr(input logic [7:0] d, input logic pbit, input logic odd);
        int ones;
        ones = $countones(d) + int'(pbit);
        return ((ones % 2) == 1) != odd;
    endfunction

    // Compare process: every data_valid pulse must match the oldest frame.
    always @(negedge clk) begin
        if (rst_n && data_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                int lat;
                e_cur = exp_q.pop_front();
                check("sb_data", 32'(data_out), 32'(e_cur.data));
                check("sb_parity_err", 32'(parity_err), 32'(e_cur.perr));
                check("sb_frame_err", 32'(frame_err), 32'(e_cur.ferr));
                lat = cyc - e_cur.start_cyc;
                total++;
                if (lat < c_LAT - 1 || lat > c_LAT + 1) begin
                    bad++;
                    $display("FAIL sb_latency: got=%0d want=%0d+-1", lat, c_LAT);
                end
            end
        end
    end

    task automatic drive_bit(input logic b);
        rx_in = b;
        repeat (c_CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic sbit, input logic odd);
        exp_t e;
        odd_sel     = odd;
        e.data      = d;
        e.perr      = model_perr(d, pbit, odd);
        e.ferr      = ~sbit;
        e.start_cyc = cyc;
        exp_q.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < c_DB; i++) drive_bit(d[i]);
        drive_bit(pbit);
        drive_bit(sbit);
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame_result(input string tag, input logic [7:0] d, input logic pe, input logic fe);
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_data"}, 32'(data_out), 32'(d));
        check({tag, "_parity_err"}, 32'(parity_err), 32'(pe));
        check({tag, "_frame_err"}, 32'(frame_err), 32'(fe));
    endtask

    task automatic wait_not_busy(input string tag, input int limit);
        int n;
        n = 0;
        while (busy && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_busy_clear"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        rst_n   = 1'b0;
        rx_in   = 1'b1;
        odd_sel = 1'b0;
        #2;
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_data_valid", 32'(data_valid), 32'd0);
        check("rst_parity_err", 32'(parity_err), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // Pin the model against hand-computed parity results.
        check("pin_a5_even_p0", 32'(model_perr(8'hA5, 1'b0, 1'b0)), 32'd0);
        check("pin_a5_even_p1", 32'(model_perr(8'hA5, 1'b1, 1'b0)), 32'd1);
        check("pin_00_odd_p1", 32'(model_perr(8'h00, 1'b1, 1'b1)), 32'd0);
        check("pin_00_odd_p0", 32'(model_perr(8'h00, 1'b0, 1'b1)), 32'd1);

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(4);

        // Good frame, even parity.
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
        idle(4);
        frame_result("a5_good", 8'hA5, 1'b0, 1'b0);

        // Same word, wrong parity bit.
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
        idle(4);
        frame_result("a5_perr", 8'hA5, 1'b1, 1'b0);

        // Odd parity on an all-zero word.
        send_frame(8'h00, 1'b1, 1'b1, 1'b1);
        idle(4);
        frame_result("00_odd_ok", 8'h00, 1'b0, 1'b0);
        send_frame(8'h00, 1'b0, 1'b1, 1'b1);
        idle(4);
        frame_result("00_odd_bad", 8'h00, 1'b1, 1'b0);

        // Extra patterns: all ones odd parity, single one even parity.
        send_frame(8'hFF, 1'b1, 1'b1, 1'b1);
        idle(4);
        frame_result("ff_odd_ok", 8'hFF, 1'b0, 1'b0);
        send_frame(8'h01, 1'b1, 1'b1, 1'b0);
        idle(4);
        frame_result("01_even_ok", 8'h01, 1'b0, 1'b0);

        // Short low glitch: rejected at mid start bit, no data_valid.
        n = cyc;
        rx_in = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx_in = 1'b1;
        check("glitch_busy_set", 32'(busy), 32'd1);
        wait_not_busy("glitch", c_CPB);
        total++;
        if (cyc - n > c_CPB / 2 + 2 + c_SYNC_LAT) begin
            bad++;
            $display("FAIL glitch_busy_time: got=%0d want<=%0d", cyc - n, c_CPB / 2 + 2 + c_SYNC_LAT);
        end
        idle(c_CPB);
        check("glitch_no_valid", 32'(exp_q.size()), 32'd0);

        // Stop bit low, line held low: frame error, waits for idle line.
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        check("brk_busy_held", 32'(busy), 32'd1);
        frame_result("3c_ferr", 8'h3C, 1'b0, 1'b1);
        rx_in = 1'b1;
        wait_not_busy("brk", 4 + c_SYNC_LAT);
        idle(4);

        // Both errors in one frame; word still delivered.
        send_frame(8'h81, 1'b1, 1'b0, 1'b0);
        rx_in = 1'b1;
        wait_not_busy("both", 4 + c_SYNC_LAT);
        idle(4);
        frame_result("81_both", 8'h81, 1'b1, 1'b1);

        // Clean frame after the errors.
        send_frame(8'h55, 1'b0, 1'b1, 1'b0);
        idle(4);
        frame_result("55_clean", 8'h55, 1'b0, 1'b0);

        // Reset in the middle of data bit 3: partial frame is discarded.
        odd_sel = 1'b0;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b0);
        rx_in = 1'b0;
        repeat (c_CPB / 2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_data_out", 32'(data_out), 32'd0);
        check("midrst_data_valid", 32'(data_valid), 32'd0);
        check("midrst_parity_err", 32'(parity_err), 32'd0);
        check("midrst_frame_err", 32'(frame_err), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        rx_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(4);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        idle(4);
        frame_result("5a_after_rst", 8'h5A, 1'b0, 1'b0);

        idle(20);
        check("final_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_parity_serial_rx
`default_nettype wire
